// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one byte-wide RAM port between the instruction-fetch
// requester (IF) and the load/store requester (MEM).
//
// Every accepted request runs as a byte-serial transaction of 1, 2 or 4
// bytes. Read bytes are assembled little-endian. Loads are zero- or
// sign-extended, and the result is returned with a one-cycle done pulse.
//
// Ports:
//   clk, rst           clock, synchronous active-high reset
//   if_req_i           fetch request (4-byte read), held until if_done_o
//   if_addr_i          fetch base address
//   if_done_o          one-cycle pulse; if_data_o is valid
//   if_data_o          fetched word
//   mem_req_i          load/store request, held until mem_done_o
//   mem_we_i           1 = store, 0 = load
//   mem_sel_i          size: 001 byte, 010 half, 100 word
//                      (000 is rejected; any other value means word)
//   mem_signed_i       sign-extend loads
//   mem_addr_i         load/store base address
//   mem_data_i         store data, byte k = bits [8k+7:8k]
//   mem_done_o         one-cycle pulse: load data valid / store complete
//   mem_data_o         extended load result, 0 after stores
//   mem_busy_o         high while an IF transaction owns the RAM port
//   ram_addr_o         RAM byte address
//   ram_wr_o           RAM write strobe
//   ram_data_o         RAM write byte
//   ram_data_i         RAM read byte, valid one cycle after its address
module mem_arbiter #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [2:0]        mem_sel_i,
  input  logic              mem_signed_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_data_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_data_o,
  output logic              mem_busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_data_o,
  input  logic [7:0]        ram_data_i
);

  typedef enum logic [1:0] {IDLE, READ, WRITE, DONE} state_t;

  state_t            state_reg;
  logic              owner_mem_reg;
  logic [ADDR_W-1:0] base_reg;
  logic [2:0]        n_reg;
  logic [2:0]        cnt_reg;
  logic              is_signed_reg;
  logic [31:0]       wdata_reg;
  logic [31:0]       rdata_reg;

  logic [2:0]  req_n;
  logic        mem_ok;
  logic [2:0]  addr_off;
  logic [7:0]  wr_byte;
  logic [1:0]  lane;
  logic [31:0] assembled;
  logic [31:0] ext;

  // Size decode: only the two small one-hot codes are narrow, the rest is a word.
  always_comb begin
    case (mem_sel_i)
      3'b001:  req_n = 3'd1;
      3'b010:  req_n = 3'd2;
      default: req_n = 3'd4;
    endcase
  end

  assign mem_ok = mem_req_i && (mem_sel_i != 3'b000);

  // During a read, cnt runs one past the last issue index while the final
  // byte returns. Clamping keeps the address on the last byte, so the port
  // holds its last value through DONE and IDLE. n_reg resets to 1, which
  // makes the reset address 0.
  always_comb begin
    addr_off = (cnt_reg == n_reg) ? (n_reg - 3'd1) : cnt_reg;
  end

  assign ram_addr_o = base_reg + ADDR_W'(addr_off);
  assign ram_wr_o   = (state_reg == WRITE);

  always_comb begin
    wr_byte = wdata_reg[{cnt_reg[1:0], 3'b000} +: 8];
  end

  assign ram_data_o = (state_reg == WRITE) ? wr_byte : 8'h00;

  // The byte on ram_data_i belongs to the address issued one cycle earlier.
  assign lane = cnt_reg[1:0] - 2'd1;

  always_comb begin
    assembled = rdata_reg;
    assembled[{lane, 3'b000} +: 8] = ram_data_i;
  end

  always_comb begin
    case (n_reg)
      3'd1:    ext = {{24{is_signed_reg & assembled[7]}}, assembled[7:0]};
      3'd2:    ext = {{16{is_signed_reg & assembled[15]}}, assembled[15:0]};
      default: ext = assembled;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg     <= IDLE;
      owner_mem_reg <= 1'b0;
      base_reg      <= '0;
      n_reg         <= 3'd1;
      cnt_reg       <= 3'd0;
      is_signed_reg <= 1'b0;
      wdata_reg     <= 32'h0;
      rdata_reg     <= 32'h0;
      if_done_o     <= 1'b0;
      if_data_o     <= 32'h0;
      mem_done_o    <= 1'b0;
      mem_data_o    <= 32'h0;
      mem_busy_o    <= 1'b0;
    end else begin
      if_done_o  <= 1'b0;
      mem_done_o <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (mem_ok) begin
            owner_mem_reg <= 1'b1;
            base_reg      <= mem_addr_i;
            n_reg         <= req_n;
            is_signed_reg <= mem_signed_i;
            wdata_reg     <= mem_data_i;
            rdata_reg     <= 32'h0;
            cnt_reg       <= 3'd0;
            state_reg     <= mem_we_i ? WRITE : READ;
          end else if (if_req_i) begin
            owner_mem_reg <= 1'b0;
            base_reg      <= if_addr_i;
            n_reg         <= 3'd4;
            is_signed_reg <= 1'b0;
            rdata_reg     <= 32'h0;
            cnt_reg       <= 3'd0;
            mem_busy_o    <= 1'b1;
            state_reg     <= READ;
          end
        end
        READ: begin
          if (cnt_reg != 3'd0) begin
            rdata_reg <= assembled;
          end
          if (cnt_reg == n_reg) begin
            state_reg <= DONE;
            if (owner_mem_reg) begin
              mem_done_o <= 1'b1;
              mem_data_o <= ext;
            end else begin
              if_done_o <= 1'b1;
              if_data_o <= assembled;
            end
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        WRITE: begin
          if (cnt_reg == n_reg - 3'd1) begin
            state_reg  <= DONE;
            mem_done_o <= 1'b1;
            mem_data_o <= 32'h0;
          end else begin
            cnt_reg <= cnt_reg + 3'd1;
          end
        end
        DONE: begin
          state_reg  <= IDLE;
          mem_busy_o <= 1'b0;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
